// File: rtl/bin_a_bcd_secuencial.sv
// Sequential double-dabble converter: signed WIDTH-bit binary to sign + BCD.
// Ports: clk, rst (sync, active high), start, num_binario -> busy, done, signo, bcd.
module bin_a_bcd_secuencial #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      num_binario,
    output logic                  busy,
    output logic                  done,
    output logic                  signo,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] acc_shift;
    logic [CW-1:0]       cnt;
    logic                s;
    logic                take;
    logic                last;
    logic [WIDTH-1:0]    mag_in;

    // A new operand is accepted from IDLE, or from DONE for back-to-back use.
    assign take   = start && (state == IDLE || state == DONE);
    assign last   = (state == SHIFT) && (cnt == CW'(1));
    assign mag_in = num_binario[WIDTH-1] ? (~num_binario + WIDTH'(1))
                                         : num_binario;

    // Add-3 on every digit >= 5, then shift the next magnitude bit in.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_shift = {adj[4*DIGITS-2:0], mag[WIDTH-1]};
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CW'(1))
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mag   <= '0;
            acc   <= '0;
            cnt   <= '0;
            s     <= 1'b0;
            bcd   <= '0;
            signo <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                s   <= num_binario[WIDTH-1];
                mag <= mag_in;
                acc <= '0;
                cnt <= CW'(WIDTH);
            end else if (state == SHIFT) begin
                acc <= acc_shift;
                mag <= {mag[WIDTH-2:0], 1'b0};
                cnt <= cnt - CW'(1);
            end
            // Results land together with the entry into DONE, so they are
            // valid during the done pulse and never show partial values.
            if (last) begin
                bcd   <= acc_shift;
                signo <= s;
            end
        end
    end

endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// Directed self-checking bench for bin_a_bcd_secuencial.
// Drives inputs on the falling edge, samples outputs on the falling edge.
module tb_bin_a_bcd_secuencial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] num_binario;
    logic        busy;
    logic        done;
    logic        signo;
    logic [15:0] bcd;

    int compared   = 0;
    int mismatched = 0;
    int n;
    int nbusy;
    int ndone;

    bin_a_bcd_secuencial #(.WIDTH(14), .DIGITS(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_binario(num_binario),
        .busy(busy),
        .done(done),
        .signo(signo),
        .bcd(bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one conversion and check latency, busy length and result.
    task automatic run(input string tag, input logic [13:0] v,
                       input logic [15:0] eb, input logic es);
        @(negedge clk);
        num_binario = v;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 15);
        chk({tag, "_busy"}, nbusy, 14);
        chk({tag, "_bcd"}, bcd, eb);
        chk({tag, "_sign"}, signo, es);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_binario = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_sign", signo, 0);
        rst = 1'b0;

        run("p1234", 14'd1234, 16'h1234, 1'b0);
        run("m1", 14'h3FFF, 16'h0001, 1'b1);
        run("zero", 14'd0, 16'h0000, 1'b0);
        run("minneg", 14'h2000, 16'h8192, 1'b1);
        run("maxpos", 14'h1FFF, 16'h8191, 1'b0);

        // Start while busy must be ignored; operand changes are ignored.
        @(negedge clk);
        num_binario = 14'd4096;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        num_binario = 14'd7;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ndone++;
                chk("ign_bcd", bcd, 16'h4096);
            end
            @(negedge clk);
        end
        chk("ign_ndone", ndone, 1);

        // Back-to-back: new start presented during the DONE cycle.
        @(negedge clk);
        num_binario = 14'd500;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat1", n, 15);
        chk("b2b_bcd1", bcd, 16'h0500);
        num_binario = 14'd99;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat2", n, 15);
        chk("b2b_bcd2", bcd, 16'h0099);
        chk("b2b_sign2", signo, 0);

        // Reset in the middle of a conversion of -3000 aborts it.
        @(negedge clk);
        num_binario = 14'h3448;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ab_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("ab_ndone", ndone, 0);
        chk("ab_bcd", bcd, 0);
        chk("ab_sign", signo, 0);
        run("m3000", 14'h3448, 16'h3000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
